// File: rtl/uctl_pulse_receiver_if.sv
// Receiver-side bundle: the req/ack handshake from the source domain
// and the valid/ready word stream to the core.
interface uctl_pulse_receiver_if #(
  parameter int DATA_WD = 8,
  parameter int DEPTH   = 4
);
  logic                     reqIn;
  logic [DATA_WD-1:0]       dataIn;
  logic                     ackOut;
  logic [DATA_WD-1:0]       dataOut;
  logic                     dataValid;
  logic                     dataReady;
  logic [$clog2(DEPTH):0]   fifoCount;

  modport master (
    output reqIn, dataIn, dataReady,
    input  ackOut, dataOut, dataValid, fifoCount
  );

  modport slave (
    input  reqIn, dataIn, dataReady,
    output ackOut, dataOut, dataValid, fifoCount
  );
endinterface

// File: rtl/uctl_pulse_receiver.sv
// Destination side of a 4-phase req/ack crossing: synchronizes reqIn, captures
// one word per request into a FWFT FIFO and answers with a registered ack level.
//
// state | meaning
// IDLE  | waiting for synchronized req; captures word when FIFO has room
// ACK   | word captured, ack held high until req falls
module uctl_pulse_receiver #(
  parameter int DATA_WD     = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock2,
  input  logic                  clock2Rst,
  uctl_pulse_receiver_if.slave  rx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic                     ack_q, ack_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DATA_WD-1:0]       mem_q [DEPTH];
  logic [DATA_WD-1:0]       mem_d [DEPTH];

  logic req_sync;
  logic full;
  logic empty;
  logic push;
  logic pop;

  assign req_sync = sync_q[SYNC_STAGES-1];
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], rx.reqIn};
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;

    // A full FIFO simply withholds the ack; the source keeps req high and we retry.
    unique case (state_q)
      IDLE: begin
        if (req_sync && !full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_sync) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
    endcase

    pop      = !empty && rx.dataReady;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = rx.dataIn;
    end
  end

  always_ff @(posedge clock2) begin
    if (clock2Rst) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      sync_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      sync_q   <= sync_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign rx.ackOut    = ack_q;
  assign rx.dataOut   = mem_q[rd_ptr_q];
  assign rx.dataValid = !empty;
  assign rx.fifoCount = count_q;

endmodule

// File: tb/tb_uctl_pulse_receiver.sv
// Scoreboard bench: words are queued as requests are issued, and a negedge
// monitor checks every word the core actually pops, in order.
module tb_uctl_pulse_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uctl_pulse_receiver_if #(.DATA_WD(8), .DEPTH(4)) bus ();

  uctl_pulse_receiver #(
    .DATA_WD(8),
    .DEPTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clock2    (clk),
    .clock2Rst (rst),
    .rx        (bus)
  );

  int         tests = 0;
  int         fails = 0;
  bit         rand_rdy = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock edge, then act 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.dataReady = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ack(input logic lvl, input string nm);
    int n = 0;
    while (bus.ackOut !== lvl && n < 200) begin
      tick();
      n++;
    end
    chk(nm, 32'(bus.ackOut), 32'(lvl));
  endtask

  task automatic do_xfer(input logic [7:0] d);
    bus.dataIn = d;
    bus.reqIn  = 1'b1;
    exp_q.push_back(d);
    wait_ack(1'b1, "ack_rise");
    bus.reqIn = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy      = 1'b0;
    bus.dataReady = 1'b1;
    while (bus.fifoCount != 0 && n < 100) begin
      tick();
      n++;
    end
    bus.dataReady = 1'b0;
    chk("drain_count", 32'(bus.fifoCount), 0);
    chk("drain_sb_empty", 32'(exp_q.size()), 0);
  endtask

  // Monitor: a word leaves the FIFO on any edge that sees valid & ready.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.dataValid === 1'b1 && bus.dataReady === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got %02h, want no word", bus.dataOut);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", 32'(bus.dataOut), 32'(e));
        end
      end
    end
  end

  initial begin
    bit         saw;
    logic [7:0] d;

    bus.reqIn     = 1'b0;
    bus.dataIn    = '0;
    bus.dataReady = 1'b0;
    rst           = 1'b1;
    tick();
    tick();
    chk("rst_ack", 32'(bus.ackOut), 0);
    chk("rst_valid", 32'(bus.dataValid), 0);
    chk("rst_count", 32'(bus.fifoCount), 0);
    chk("rst_dout", 32'(bus.dataOut), 0);
    rst = 1'b0;
    tick();

    // Single transfer latency, ack rise and fall.
    bus.dataIn    = 8'hA5;
    bus.dataReady = 1'b1;
    bus.reqIn     = 1'b1;
    exp_q.push_back(8'hA5);
    tick(); chk("lat_ack_e0", 32'(bus.ackOut), 0);
    tick(); chk("lat_ack_e1", 32'(bus.ackOut), 0);
    tick();
    chk("lat_ack_e2", 32'(bus.ackOut), 1);
    chk("lat_valid_e2", 32'(bus.dataValid), 1);
    chk("lat_dout_e2", 32'(bus.dataOut), 32'h A5);
    tick();
    chk("lat_popped_count", 32'(bus.fifoCount), 0);
    bus.reqIn = 1'b0;
    tick(); tick();
    chk("fall_ack_e1", 32'(bus.ackOut), 1);
    tick();
    chk("fall_ack_e2", 32'(bus.ackOut), 0);
    bus.dataReady = 1'b0;

    // Fill, then backpressure on the fifth request.
    for (int i = 1; i <= 4; i++) do_xfer(8'(i));
    chk("fill_count", 32'(bus.fifoCount), 4);
    bus.dataIn = 8'h05;
    bus.reqIn  = 1'b1;
    exp_q.push_back(8'h05);
    saw = 1'b0;
    repeat (6) begin
      tick();
      if (bus.ackOut) saw = 1'b1;
    end
    chk("full_stall_ack", 32'(saw), 0);
    chk("full_stall_count", 32'(bus.fifoCount), 4);
    bus.dataReady = 1'b1;
    tick();
    bus.dataReady = 1'b0;
    chk("full_pop_count", 32'(bus.fifoCount), 3);
    chk("full_pop_ack", 32'(bus.ackOut), 0);
    tick();
    chk("full_retry_count", 32'(bus.fifoCount), 4);
    chk("full_retry_ack", 32'(bus.ackOut), 1);
    bus.reqIn = 1'b0;
    wait_ack(1'b0, "full_ack_fall");
    drain();

    // Ordering across pointer wrap with random consumer readiness.
    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_xfer(8'(i));
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();

    // Long request: exactly one write.
    d          = 8'($urandom);
    bus.dataIn = d;
    bus.reqIn  = 1'b1;
    exp_q.push_back(d);
    tick(); tick(); tick();
    saw = 1'b0;
    repeat (47) begin
      tick();
      if (!bus.ackOut) saw = 1'b1;
    end
    chk("long_ack_drop", 32'(saw), 0);
    chk("long_count", 32'(bus.fifoCount), 1);
    bus.reqIn = 1'b0;
    wait_ack(1'b0, "long_ack_fall");
    chk("long_count_after", 32'(bus.fifoCount), 1);
    drain();

    // Simultaneous push/pop at count=2, then at count=4.
    do_xfer(8'h21);
    do_xfer(8'h22);
    d          = 8'($urandom);
    bus.dataIn = d;
    bus.reqIn  = 1'b1;
    exp_q.push_back(d);
    tick(); tick();
    bus.dataReady = 1'b1;
    tick();
    bus.dataReady = 1'b0;
    chk("pp2_count", 32'(bus.fifoCount), 2);
    chk("pp2_ack", 32'(bus.ackOut), 1);
    bus.reqIn = 1'b0;
    wait_ack(1'b0, "pp2_ack_fall");
    do_xfer(8'h41);
    do_xfer(8'h42);
    chk("pp4_pre_count", 32'(bus.fifoCount), 4);
    bus.dataIn = 8'h43;
    bus.reqIn  = 1'b1;
    exp_q.push_back(8'h43);
    tick(); tick();
    bus.dataReady = 1'b1;
    tick();
    bus.dataReady = 1'b0;
    chk("pp4_pop_count", 32'(bus.fifoCount), 3);
    chk("pp4_pop_ack", 32'(bus.ackOut), 0);
    tick();
    chk("pp4_push_count", 32'(bus.fifoCount), 4);
    bus.reqIn = 1'b0;
    wait_ack(1'b0, "pp4_ack_fall");
    drain();

    // Reset while in ACK with req still asserted.
    d          = 8'($urandom);
    bus.dataIn = d;
    bus.reqIn  = 1'b1;
    exp_q.push_back(d);
    wait_ack(1'b1, "rstack_rise");
    rst = 1'b1;
    tick();
    chk("rstack_ack", 32'(bus.ackOut), 0);
    chk("rstack_count", 32'(bus.fifoCount), 0);
    chk("rstack_valid", 32'(bus.dataValid), 0);
    exp_q.delete();
    exp_q.push_back(d);
    rst = 1'b0;
    tick(); tick();
    chk("rstack_relat_e1", 32'(bus.ackOut), 0);
    tick();
    chk("rstack_relat_e2", 32'(bus.ackOut), 1);
    chk("rstack_recount", 32'(bus.fifoCount), 1);
    bus.reqIn = 1'b0;
    wait_ack(1'b0, "rstack_ack_fall");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
